// File: rtl/fft_pkg.sv
// Shared constants and types for the 512-point radix-2 FFT pipeline.
package fft_pkg;

  localparam int unsigned N_FFT      = 512;
  localparam int unsigned LANES      = 16;
  localparam int unsigned BEATS      = 32;
  localparam int unsigned HALF_BEATS = 16;
  localparam int unsigned W_IN       = 9;
  localparam int unsigned W_B0       = 10;
  localparam int unsigned W_CNT      = $clog2(BEATS);
  localparam int unsigned W_ROW      = $clog2(HALF_BEATS);

  typedef logic signed [W_IN-1:0] sample_t;
  typedef logic signed [W_B0-1:0] bfly0_t;
  typedef logic [W_CNT-1:0]       beat_t;

  // Which half of a frame a beat belongs to.
  typedef enum logic {
    PH_STORE = 1'b0,
    PH_BFLY  = 1'b1
  } phase_e;

  // The top bit of the beat counter selects the frame half.
  function automatic phase_e phase_of(input beat_t cnt);
    return phase_e'(cnt[W_CNT-1]);
  endfunction

endpackage

// File: rtl/step0_0_bfly2.sv
// One combinational radix-2 butterfly: sum and difference of two complex samples.
module bfly2
  import fft_pkg::*;
(
  input  sample_t a_re,
  input  sample_t a_im,
  input  sample_t b_re,
  input  sample_t b_im,
  output bfly0_t  sum_re,
  output bfly0_t  sum_im,
  output bfly0_t  dif_re,
  output bfly0_t  dif_im
);

  // Operands are sign-extended to the output width, so the result is exact.
  always_comb begin
    sum_re = bfly0_t'(a_re) + bfly0_t'(b_re);
    sum_im = bfly0_t'(a_im) + bfly0_t'(b_im);
    dif_re = bfly0_t'(a_re) - bfly0_t'(b_re);
    dif_im = bfly0_t'(a_im) - bfly0_t'(b_im);
  end

endmodule

// File: rtl/step0_0.sv
// FFT stage 0 / sub-stage 0: buffers the first half-frame, then forms
// x[n] +/- x[n+256] row by row while the second half streams in.
module step0_0
  import fft_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid,
  input  sample_t din_re      [0:LANES-1],
  input  sample_t din_im      [0:LANES-1],
  output bfly0_t  bfly00_re_p [0:HALF_BEATS-1][0:LANES-1],
  output bfly0_t  bfly00_im_p [0:HALF_BEATS-1][0:LANES-1],
  output bfly0_t  bfly00_re_n [0:HALF_BEATS-1][0:LANES-1],
  output bfly0_t  bfly00_im_n [0:HALF_BEATS-1][0:LANES-1]
);

  beat_t            cnt_q;
  beat_t            cnt_d;
  phase_e           phase;
  logic [W_ROW-1:0] row;

  sample_t buf_re_q [0:HALF_BEATS-1][0:LANES-1];
  sample_t buf_im_q [0:HALF_BEATS-1][0:LANES-1];

  bfly0_t re_p_q [0:HALF_BEATS-1][0:LANES-1];
  bfly0_t im_p_q [0:HALF_BEATS-1][0:LANES-1];
  bfly0_t re_n_q [0:HALF_BEATS-1][0:LANES-1];
  bfly0_t im_n_q [0:HALF_BEATS-1][0:LANES-1];

  bfly0_t s_re [0:LANES-1];
  bfly0_t s_im [0:LANES-1];
  bfly0_t d_re [0:LANES-1];
  bfly0_t d_im [0:LANES-1];

  // Both halves address the same row index: buffer row b, or output row b-16.
  assign row   = cnt_q[W_ROW-1:0];
  assign phase = phase_of(cnt_q);

  // Beat counter advance; natural 5-bit wrap starts the next frame.
  always_comb begin
    cnt_d = cnt_q + beat_t'(1);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bfly2 u_bfly (
      .a_re   (buf_re_q[row][g]),
      .a_im   (buf_im_q[row][g]),
      .b_re   (din_re[g]),
      .b_im   (din_im[g]),
      .sum_re (s_re[g]),
      .sum_im (s_im[g]),
      .dif_re (d_re[g]),
      .dif_im (d_im[g])
    );
  end

  // Counter, input buffer and output rows; everything freezes while valid=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < HALF_BEATS; i++) begin
        for (int unsigned j = 0; j < LANES; j++) begin
          buf_re_q[i][j] <= '0;
          buf_im_q[i][j] <= '0;
          re_p_q[i][j]   <= '0;
          im_p_q[i][j]   <= '0;
          re_n_q[i][j]   <= '0;
          im_n_q[i][j]   <= '0;
        end
      end
    end else if (valid) begin
      cnt_q <= cnt_d;
      if (phase == PH_STORE) begin
        for (int unsigned j = 0; j < LANES; j++) begin
          buf_re_q[row][j] <= din_re[j];
          buf_im_q[row][j] <= din_im[j];
        end
      end else begin
        for (int unsigned j = 0; j < LANES; j++) begin
          re_p_q[row][j] <= s_re[j];
          im_p_q[row][j] <= s_im[j];
          re_n_q[row][j] <= d_re[j];
          im_n_q[row][j] <= d_im[j];
        end
      end
    end
  end

  assign bfly00_re_p = re_p_q;
  assign bfly00_im_p = im_p_q;
  assign bfly00_re_n = re_n_q;
  assign bfly00_im_n = im_n_q;

endmodule

// File: tb/tb_step0_0.sv
// Bench for step0_0: scoreboarded row checks per beat plus full-array model checks.
module tb_step0_0;
  import fft_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    valid;
  sample_t din_re [0:15];
  sample_t din_im [0:15];
  bfly0_t  o_rp [0:15][0:15];
  bfly0_t  o_ip [0:15][0:15];
  bfly0_t  o_rn [0:15][0:15];
  bfly0_t  o_in [0:15][0:15];

  step0_0 dut (
    .clk         (clk),
    .rst         (rst_n),
    .valid       (valid),
    .din_re      (din_re),
    .din_im      (din_im),
    .bfly00_re_p (o_rp),
    .bfly00_im_p (o_ip),
    .bfly00_re_n (o_rn),
    .bfly00_im_n (o_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int xr [0:511];
  int xi [0:511];

  int m_rp [0:15][0:15];
  int m_ip [0:15][0:15];
  int m_rn [0:15][0:15];
  int m_in [0:15][0:15];

  typedef struct {
    int k;
    int rp [0:15];
    int ip [0:15];
    int rn [0:15];
    int in_ [0:15];
  } row_t;

  row_t sb [$];

  typedef struct {
    int ar, ai, br, bi;
    int erp, eip, ern, ein;
  } vec_t;

  task automatic chk_row(input string name, input int k, input int which, input int exp [0:15]);
    int act;
    int bad_lane;
    bad_lane = -1;
    for (int j = 0; j < 16; j++) begin
      case (which)
        0: act = int'(o_rp[k][j]);
        1: act = int'(o_ip[k][j]);
        2: act = int'(o_rn[k][j]);
        default: act = int'(o_in[k][j]);
      endcase
      if (act != exp[j] && bad_lane < 0) bad_lane = j;
    end
    total++;
    if (bad_lane >= 0) begin
      bad++;
      case (which)
        0: act = int'(o_rp[k][bad_lane]);
        1: act = int'(o_ip[k][bad_lane]);
        2: act = int'(o_rn[k][bad_lane]);
        default: act = int'(o_in[k][bad_lane]);
      endcase
      $display("FAIL %s arr=%0d row=%0d lane=%0d got=%0d want=%0d",
               name, which, k, bad_lane, act, exp[bad_lane]);
    end
  endtask

  task automatic check_all(input string name);
    for (int k = 0; k < 16; k++) begin
      chk_row(name, k, 0, m_rp[k]);
      chk_row(name, k, 1, m_ip[k]);
      chk_row(name, k, 2, m_rn[k]);
      chk_row(name, k, 3, m_in[k]);
    end
  endtask

  task automatic check_const(input string name, input vec_t v);
    int e [0:15];
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) e[j] = v.erp;
      chk_row(name, k, 0, e);
      for (int j = 0; j < 16; j++) e[j] = v.eip;
      chk_row(name, k, 1, e);
      for (int j = 0; j < 16; j++) e[j] = v.ern;
      chk_row(name, k, 2, e);
      for (int j = 0; j < 16; j++) e[j] = v.ein;
      chk_row(name, k, 3, e);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 16; j++) begin
        m_rp[k][j] = 0; m_ip[k][j] = 0; m_rn[k][j] = 0; m_in[k][j] = 0;
      end
  endtask

  // Drives beats 0..last of the frame in xr/xi; optional 3-cycle gaps after beats g1/g2.
  task automatic send_frame(input int g1, input int g2, input int last, input bit full_chk);
    row_t r, got;
    for (int b = 0; b <= last; b++) begin
      for (int j = 0; j < 16; j++) begin
        din_re[j] = sample_t'(xr[16*b+j]);
        din_im[j] = sample_t'(xi[16*b+j]);
      end
      valid = 1'b1;
      if (b >= 16) begin
        r.k = b - 16;
        for (int j = 0; j < 16; j++) begin
          r.rp[j]  = xr[16*r.k+j] + xr[256+16*r.k+j];
          r.ip[j]  = xi[16*r.k+j] + xi[256+16*r.k+j];
          r.rn[j]  = xr[16*r.k+j] - xr[256+16*r.k+j];
          r.in_[j] = xi[16*r.k+j] - xi[256+16*r.k+j];
          m_rp[r.k][j] = r.rp[j];
          m_ip[r.k][j] = r.ip[j];
          m_rn[r.k][j] = r.rn[j];
          m_in[r.k][j] = r.in_[j];
        end
        sb.push_back(r);
      end
      @(posedge clk);
      #1;
      if (b >= 16) begin
        got = sb.pop_front();
        chk_row("sb_rp", got.k, 0, got.rp);
        chk_row("sb_ip", got.k, 1, got.ip);
        chk_row("sb_rn", got.k, 2, got.rn);
        chk_row("sb_in", got.k, 3, got.in_);
      end
      if (full_chk) check_all("progressive");
      if (b == g1 || b == g2) begin
        valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
          din_re[j] = sample_t'(-7);
          din_im[j] = sample_t'(9);
        end
        repeat (3) @(posedge clk);
        #1;
        check_all("gap_hold");
      end
    end
    valid = 1'b0;
  endtask

  task automatic fill_const(input vec_t v);
    for (int n = 0; n < 512; n++) begin
      xr[n] = (n < 256) ? v.ar : v.br;
      xi[n] = (n < 256) ? v.ai : v.bi;
    end
  endtask

  task automatic fill_random();
    for (int n = 0; n < 512; n++) begin
      xr[n] = int'($urandom_range(511)) - 256;
      xi[n] = int'($urandom_range(511)) - 256;
    end
  endtask

  vec_t vt [0:6];

  initial begin
    vt[0] = '{ar:1,    ai:-1,   br:1,    bi:-1,   erp:2,   eip:-2,   ern:0,    ein:0};
    vt[1] = '{ar:255,  ai:0,    br:255,  bi:0,    erp:510, eip:0,    ern:0,    ein:0};
    vt[2] = '{ar:-256, ai:0,    br:255,  bi:0,    erp:-1,  eip:0,    ern:-511, ein:0};
    vt[3] = '{ar:0,    ai:-256, br:0,    bi:-256, erp:0,   eip:-512, ern:0,    ein:0};
    vt[4] = '{ar:-256, ai:-256, br:255,  bi:255,  erp:-1,  eip:-1,   ern:-511, ein:-511};
    vt[5] = '{ar:255,  ai:255,  br:-256, bi:-256, erp:-1,  eip:-1,   ern:511,  ein:511};
    vt[6] = '{ar:-3,   ai:7,    br:5,    bi:-2,   erp:2,   eip:5,    ern:-8,   ein:9};

    rst_n = 1'b1;
    valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      din_re[j] = '0;
      din_im[j] = '0;
    end
    model_clear();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_all("idle_after_reset");

    // Cosine / sine frame.
    for (int n = 0; n < 512; n++) begin
      xr[n] = int'(255.0 * $cos(2.0 * 3.14159265358979 * 5.0 * n / 512.0));
      xi[n] = int'(255.0 * $sin(2.0 * 3.14159265358979 * 5.0 * n / 512.0));
    end
    send_frame(-1, -1, 31, 1'b0);
    repeat (5) @(posedge clk);
    #1 check_all("cosine");

    // Constant and extreme frames from the vector table.
    for (int t = 0; t < 7; t++) begin
      fill_const(vt[t]);
      send_frame(-1, -1, 31, 1'b0);
      #1 check_const($sformatf("vec%0d", t), vt[t]);
    end

    // Same random frame without and with gaps.
    fill_random();
    send_frame(-1, -1, 31, 1'b0);
    #1 check_all("random_nogap");
    send_frame(5, 20, 31, 1'b0);
    #1 check_all("random_gaps");

    // Reset in the middle of a frame.
    fill_random();
    send_frame(-1, -1, 20, 1'b0);
    rst_n = 1'b0;
    model_clear();
    #1 check_all("mid_reset_async");
    repeat (2) @(posedge clk);
    #1 check_all("mid_reset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vt[0] = '{ar:3, ai:3, br:3, bi:3, erp:6, eip:6, ern:0, ein:0};
    fill_const(vt[0]);
    send_frame(-1, -1, 31, 1'b0);
    #1 check_const("const3_after_reset", vt[0]);

    // Back-to-back frame overwrites one row per second-half beat.
    vt[1] = '{ar:5, ai:-4, br:2, bi:1, erp:7, eip:-3, ern:3, ein:-5};
    fill_const(vt[1]);
    send_frame(-1, -1, 31, 1'b1);
    #1 check_const("back_to_back", vt[1]);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout reached got=hang want=finish");
    $fatal(1, "timeout");
  end

endmodule
